// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order completion queue. Allocates tags at issue, captures
// CDB writebacks by tag, bypasses operands to issue and retires one entry per cycle.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueFlag,
  input  logic [1:0]           issueType,
  input  logic [4:0]           issueRd,
  input  logic [31:0]          issueVal,
  input  logic                 issueReady,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPc,
  output logic [ROB_WIDTH-1:0] issueTag,
  output logic                 full,
  output logic                 empty,
  input  logic                 aluFlag,
  input  logic [31:0]          aluVal,
  input  logic [ROB_WIDTH-1:0] aluDest,
  input  logic                 lsbFlag,
  input  logic [31:0]          lsbVal,
  input  logic [ROB_WIDTH-1:0] lsbDest,
  input  logic [ROB_WIDTH-1:0] q1Tag,
  input  logic [ROB_WIDTH-1:0] q2Tag,
  output logic                 q1Ready,
  output logic                 q2Ready,
  output logic [31:0]          q1Val,
  output logic [31:0]          q2Val,
  output logic                 commitFlag,
  output logic [4:0]           commitRd,
  output logic [31:0]          commitVal,
  output logic [ROB_WIDTH-1:0] commitTag,
  output logic                 storeCommitFlag,
  output logic [ROB_WIDTH-1:0] storeCommitTag,
  output logic                 flushFlag,
  output logic [31:0]          flushPc
);

  localparam int unsigned RobSize = 2 ** ROB_WIDTH;
  localparam logic [1:0] TypeBranch = 2'd1;
  localparam logic [1:0] TypeStore  = 2'd2;

  logic [RobSize-1:0]   busy_q, rdy_q, pred_q;
  logic [1:0]           type_q [RobSize];
  logic [4:0]           rd_q   [RobSize];
  logic [31:0]          val_q  [RobSize];
  logic [31:0]          alt_q  [RobSize];
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [ROB_WIDTH:0]   count_q;

  logic head_done, head_branch, head_store, mispredict, issue_ok;

  assign issueTag = tail_q;
  assign full     = (count_q == (ROB_WIDTH + 1)'(RobSize));
  assign empty    = (count_q == '0);

  // Stored result first, then bus bypass with LSB taking priority over ALU.
  always_comb begin
    q1Ready = 1'b0;
    q1Val   = '0;
    if (busy_q[q1Tag] && rdy_q[q1Tag]) begin
      q1Ready = 1'b1;
      q1Val   = val_q[q1Tag];
    end else if (lsbFlag && lsbDest == q1Tag) begin
      q1Ready = 1'b1;
      q1Val   = lsbVal;
    end else if (aluFlag && aluDest == q1Tag) begin
      q1Ready = 1'b1;
      q1Val   = aluVal;
    end
  end

  always_comb begin
    q2Ready = 1'b0;
    q2Val   = '0;
    if (busy_q[q2Tag] && rdy_q[q2Tag]) begin
      q2Ready = 1'b1;
      q2Val   = val_q[q2Tag];
    end else if (lsbFlag && lsbDest == q2Tag) begin
      q2Ready = 1'b1;
      q2Val   = lsbVal;
    end else if (aluFlag && aluDest == q2Tag) begin
      q2Ready = 1'b1;
      q2Val   = aluVal;
    end
  end

  always_comb begin
    head_done   = busy_q[head_q] & rdy_q[head_q];
    head_branch = (type_q[head_q] == TypeBranch);
    head_store  = (type_q[head_q] == TypeStore);
    mispredict  = head_done & head_branch & (val_q[head_q][0] != pred_q[head_q]);
    issue_ok    = issueFlag & ~full;
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      rdy_q           <= '0;
      pred_q          <= '0;
      for (int i = 0; i < RobSize; i++) begin
        type_q[i] <= '0;
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
        alt_q[i]  <= '0;
      end
      commitFlag      <= 1'b0;
      commitRd        <= '0;
      commitVal       <= '0;
      commitTag       <= '0;
      storeCommitFlag <= 1'b0;
      storeCommitTag  <= '0;
      flushFlag       <= 1'b0;
      flushPc         <= '0;
    end else if (!readyIn) begin
      commitFlag      <= 1'b0;
      storeCommitFlag <= 1'b0;
      flushFlag       <= 1'b0;
    end else begin
      commitFlag      <= 1'b0;
      storeCommitFlag <= 1'b0;
      flushFlag       <= 1'b0;
      if (mispredict) begin
        // Whole window is wrong-path; same-cycle issue is discarded too.
        flushFlag <= 1'b1;
        flushPc   <= alt_q[head_q];
        busy_q    <= '0;
        rdy_q     <= '0;
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
      end else begin
        if (aluFlag && busy_q[aluDest]) begin
          rdy_q[aluDest] <= 1'b1;
          val_q[aluDest] <= aluVal;
        end
        if (lsbFlag && busy_q[lsbDest]) begin
          rdy_q[lsbDest] <= 1'b1;
          val_q[lsbDest] <= lsbVal;
        end
        if (head_done) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + ROB_WIDTH'(1);
          if (head_store) begin
            storeCommitFlag <= 1'b1;
            storeCommitTag  <= head_q;
          end else if (!head_branch) begin
            commitFlag <= 1'b1;
            commitRd   <= rd_q[head_q];
            commitVal  <= val_q[head_q];
            commitTag  <= head_q;
          end
        end
        if (issue_ok) begin
          busy_q[tail_q] <= 1'b1;
          rdy_q[tail_q]  <= issueReady;
          pred_q[tail_q] <= issuePredTaken;
          type_q[tail_q] <= issueType;
          rd_q[tail_q]   <= issueRd;
          val_q[tail_q]  <= issueVal;
          alt_q[tail_q]  <= issueAltPc;
          tail_q         <= tail_q + ROB_WIDTH'(1);
        end
        case ({issue_ok, head_done})
          2'b10:   count_q <= count_q + (ROB_WIDTH + 1)'(1);
          2'b01:   count_q <= count_q - (ROB_WIDTH + 1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
